// File: rtl/proc_alloc_pkg.sv
// Shared constants and types for the register index allocator.
package proc_alloc_pkg;

  localparam int N_ENTRIES = 32;
  localparam int IDX_W     = 5;

  typedef logic [IDX_W-1:0]     idx_t;
  typedef logic [N_ENTRIES-1:0] map_t;

endpackage

// File: rtl/prio_enc2.sv
// Combinational encoder returning the lowest and next-lowest set bits of a bitmap.
module prio_enc2
  import proc_alloc_pkg::*;
(
  input  map_t map,
  output idx_t first,
  output logic first_vld,
  output idx_t second,
  output logic second_vld
);

  map_t rest;

  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves one unassigned (no latch).
    first      = '0;
    first_vld  = 1'b0;
    second     = '0;
    second_vld = 1'b0;
    // Clearing the lowest set bit turns "second lowest" into "lowest of the rest".
    rest       = map & (map - map_t'(1));
    for (int i = 0; i < N_ENTRIES; i++) begin
      if (map[i] && !first_vld) begin
        first     = idx_t'(i);
        first_vld = 1'b1;
      end
      if (rest[i] && !second_vld) begin
        second     = idx_t'(i);
        second_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg_index_alloc.sv
// Free-bitmap register index allocator: two grants and two releases per cycle,
// with an optional permanently reserved entry 0.
module reg_index_alloc #(
  parameter int N_ENTRIES    = proc_alloc_pkg::N_ENTRIES,
  parameter int IDX_W        = proc_alloc_pkg::IDX_W,
  parameter bit RESERVE_ZERO = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           alloc_req,
  output logic [1:0]           alloc_valid,
  output logic [IDX_W-1:0]     alloc_idx0,
  output logic [IDX_W-1:0]     alloc_idx1,
  input  logic [1:0]           free_en,
  input  logic [IDX_W-1:0]     free_idx0,
  input  logic [IDX_W-1:0]     free_idx1,
  output logic [IDX_W:0]       free_count,
  output logic [N_ENTRIES-1:0] busy_vec,
  output logic                 err_double_free
);
  import proc_alloc_pkg::*;

  typedef logic [IDX_W:0] cnt_t;

  localparam map_t RESET_MAP   = ~map_t'(RESERVE_ZERO);
  localparam cnt_t RESET_COUNT = cnt_t'(N_ENTRIES) - cnt_t'(RESERVE_ZERO);
  localparam cnt_t CNT_ONE     = cnt_t'(1);
  localparam cnt_t CNT_TWO     = cnt_t'(2);

  map_t free_map, free_map_next;
  cnt_t free_count_q, free_count_next;
  logic err_q, err_next;

  idx_t first, second, idx1_sel;
  logic first_vld, second_vld;
  logic grant0, grant1;
  logic zero0, zero1, dup, legal0, legal1;
  map_t grant_oh, rel_oh;

  prio_enc2 u_enc (
    .map        (free_map),
    .first      (first),
    .first_vld  (first_vld),
    .second     (second),
    .second_vld (second_vld)
  );

  // Grants look only at the registered bitmap, so a same-cycle release never bypasses.
  always_comb begin
    grant0   = alloc_req[0] && first_vld && (free_count_q >= CNT_ONE);
    grant1   = 1'b0;
    idx1_sel = first;
    if (alloc_req[0]) begin
      grant1   = alloc_req[1] && second_vld && (free_count_q >= CNT_TWO);
      idx1_sel = second;
    end else begin
      grant1   = alloc_req[1] && first_vld && (free_count_q >= CNT_ONE);
    end
  end

  always_comb begin
    zero0  = RESERVE_ZERO && (free_idx0 == '0);
    zero1  = RESERVE_ZERO && (free_idx1 == '0);
    dup    = (&free_en) && (free_idx0 == free_idx1);
    legal0 = free_en[0] && !zero0 && !free_map[free_idx0];
    // Port 1 defers to port 0 on a duplicate so the entry is counted once.
    legal1 = free_en[1] && !zero1 && !free_map[free_idx1] && !dup;

    err_next = (free_en[0] && !zero0 && free_map[free_idx0])
            || (free_en[1] && !zero1 && free_map[free_idx1])
            || (dup && legal0);

    grant_oh = '0;
    if (grant0) grant_oh[first]    = 1'b1;
    if (grant1) grant_oh[idx1_sel] = 1'b1;

    rel_oh = '0;
    if (legal0) rel_oh[free_idx0] = 1'b1;
    if (legal1) rel_oh[free_idx1] = 1'b1;

    free_map_next   = (free_map & ~grant_oh) | rel_oh;
    free_count_next = free_count_q - cnt_t'(grant0) - cnt_t'(grant1)
                    + cnt_t'(legal0) + cnt_t'(legal1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      free_map     <= RESET_MAP;
      free_count_q <= RESET_COUNT;
      err_q        <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every register samples the pre-edge values.
      free_map     <= free_map_next;
      free_count_q <= free_count_next;
      err_q        <= err_next;
    end
  end

  assign alloc_valid     = {grant1, grant0};
  assign alloc_idx0      = grant0 ? first : '0;
  assign alloc_idx1      = grant1 ? idx1_sel : '0;
  assign free_count      = free_count_q;
  assign busy_vec        = ~free_map;
  assign err_double_free = err_q;

endmodule

// File: tb/tb_reg_index_alloc.sv
// Scoreboard bench for reg_index_alloc: stimulus queues expectations, a negedge monitor checks them.
module tb_reg_index_alloc;
  import proc_alloc_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] alloc_req, alloc_valid, free_en;
  idx_t       alloc_idx0, alloc_idx1, free_idx0, free_idx1;
  logic [5:0] free_count;
  map_t       busy_vec;
  logic       err_double_free;

  reg_index_alloc dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .alloc_req       (alloc_req),
    .alloc_valid     (alloc_valid),
    .alloc_idx0      (alloc_idx0),
    .alloc_idx1      (alloc_idx1),
    .free_en         (free_en),
    .free_idx0       (free_idx0),
    .free_idx1       (free_idx1),
    .free_count      (free_count),
    .busy_vec        (busy_vec),
    .err_double_free (err_double_free)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    bit         chk_grant;
    logic [1:0] valid;
    idx_t       i0;
    idx_t       i1;
    bit         chk_state;
    logic [5:0] cnt;
    map_t       busy;
    logic       err;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input string name, input bit cg, input logic [1:0] v,
                              input int i0, input int i1, input bit cs, input int cnt,
                              input map_t busy, input logic err);
    exp_t e;
    e.name = name; e.chk_grant = cg; e.valid = v; e.i0 = idx_t'(i0); e.i1 = idx_t'(i1);
    e.chk_state = cs; e.cnt = 6'(cnt); e.busy = busy; e.err = err;
    return e;
  endfunction

  // Monitor: one expectation per driven cycle, compared at the falling edge.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      if (e.chk_grant) begin
        check({e.name, ".valid"}, alloc_valid, e.valid);
        check({e.name, ".idx0"},  alloc_idx0,  e.i0);
        check({e.name, ".idx1"},  alloc_idx1,  e.i1);
      end
      if (e.chk_state) begin
        check({e.name, ".count"}, free_count,      e.cnt);
        check({e.name, ".busy"},  busy_vec,        e.busy);
        check({e.name, ".err"},   err_double_free, e.err);
      end
    end
  end

  task automatic step(input logic [1:0] req, input logic [1:0] fen,
                      input int f0, input int f1, input exp_t e);
    @(posedge clk);
    #1;
    alloc_req = req;
    free_en   = fen;
    free_idx0 = idx_t'(f0);
    free_idx1 = idx_t'(f1);
    sb_q.push_back(e);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0; alloc_req = '0; free_en = '0;
    #12;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; alloc_req = '0; free_en = '0; free_idx0 = '0; free_idx1 = '0;
    #12 rst_n = 1'b1;

    step(2'b00, 2'b00, 0, 0, mk("reset",      1, 2'b00, 0, 0, 1, 31, 32'h0000_0001, 0));
    step(2'b11, 2'b00, 0, 0, mk("dual_grant", 1, 2'b11, 1, 2, 1, 31, 32'h0000_0001, 0));
    step(2'b00, 2'b00, 0, 0, mk("after_dual", 1, 2'b00, 0, 0, 1, 29, 32'h0000_0007, 0));

    do_reset();
    step(2'b10, 2'b00, 0, 0, mk("port1_only", 1, 2'b10, 0, 1, 1, 31, 32'h0000_0001, 0));
    for (int k = 0; k < 14; k++)
      step(2'b11, 2'b00, 0, 0, mk("fill", 1, 2'b11, 2 + 2 * k, 3 + 2 * k, 0, 0, '0, 0));
    step(2'b01, 2'b00, 0, 0, mk("fill_last",   1, 2'b01, 30, 0, 1, 2, 32'h3FFF_FFFF, 0));
    step(2'b11, 2'b00, 0, 0, mk("one_left",    1, 2'b01, 31, 0, 1, 1, 32'h7FFF_FFFF, 0));
    step(2'b01, 2'b01, 7, 0, mk("empty_rel",   1, 2'b00, 0,  0, 1, 0, 32'hFFFF_FFFF, 0));
    step(2'b01, 2'b00, 0, 0, mk("rel_regrant", 1, 2'b01, 7,  0, 1, 1, 32'hFFFF_FF7F, 0));
    step(2'b00, 2'b00, 0, 0, mk("empty_again", 1, 2'b00, 0,  0, 1, 0, 32'hFFFF_FFFF, 0));

    step(2'b00, 2'b01, 9, 0, mk("free9",       1, 2'b00, 0, 0, 1, 0, 32'hFFFF_FFFF, 0));
    step(2'b00, 2'b01, 9, 0, mk("dbl9_issue",  0, 2'b00, 0, 0, 1, 1, 32'hFFFF_FDFF, 0));
    step(2'b00, 2'b00, 0, 0, mk("dbl9_pulse",  0, 2'b00, 0, 0, 1, 1, 32'hFFFF_FDFF, 1));
    step(2'b00, 2'b00, 0, 0, mk("dbl9_clear",  0, 2'b00, 0, 0, 1, 1, 32'hFFFF_FDFF, 0));
    step(2'b00, 2'b11, 12, 12, mk("dup12_issue", 0, 2'b00, 0, 0, 1, 1, 32'hFFFF_FDFF, 0));
    step(2'b00, 2'b00, 0, 0, mk("dup12_pulse", 0, 2'b00, 0, 0, 1, 2, 32'hFFFF_EDFF, 1));
    step(2'b00, 2'b01, 0, 0, mk("dup12_clear", 0, 2'b00, 0, 0, 1, 2, 32'hFFFF_EDFF, 0));
    step(2'b00, 2'b00, 0, 0, mk("zero_rel",    1, 2'b00, 0, 0, 1, 2, 32'hFFFF_EDFF, 0));
    step(2'b10, 2'b00, 0, 0, mk("p1_first",    1, 2'b10, 0, 9, 1, 2, 32'hFFFF_EDFF, 0));
    step(2'b00, 2'b00, 0, 0, mk("p1_after",    1, 2'b00, 0, 0, 1, 1, 32'hFFFF_EFFF, 0));

    do_reset();
    for (int k = 0; k < 10; k++)
      step(2'b11, 2'b00, 0, 0, mk("alloc20", 1, 2'b11, 1 + 2 * k, 2 + 2 * k, 0, 0, '0, 0));
    step(2'b00, 2'b00, 0, 0, mk("twenty", 1, 2'b00, 0, 0, 1, 11, 32'h001F_FFFF, 0));

    @(posedge clk);
    #3;
    rst_n = 1'b0; alloc_req = 2'b11;
    #1;
    check("async.count", free_count,      31);
    check("async.busy",  busy_vec,        32'h0000_0001);
    check("async.err",   err_double_free, 0);
    check("async.valid", alloc_valid,     2'b11);
    check("async.idx0",  alloc_idx0,      1);
    check("async.idx1",  alloc_idx1,      2);
    #10;
    alloc_req = '0;
    rst_n = 1'b1;

    for (int w = 0; w < 10 && sb_q.size() > 0; w++) @(negedge clk);
    check("drain", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/reg_index_alloc.md
# reg_index_alloc

Index allocator that tracks a pool of 32 register entries as a free bitmap and hands out up to two free indices per cycle, priority-encoding the bitmap back to 5-bit indices. It also accepts up to two index releases per cycle. It sits in the processor's rename/issue path beside the write-enable decoders. The allocator produces the indices; the decoders later turn those indices back into one-hot enables.

## Interface
Parameters:
- N_ENTRIES, 32: pool size; must equal 2**IDX_W.
- IDX_W, 5: index width.
- RESERVE_ZERO, 1: when 1, entry 0 is never allocated, and releases of entry 0 are ignored.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- alloc_req  in  2  per-port allocation request; bit 0 is port 0.
- alloc_valid  out  2  per-port grant, combinational from state and alloc_req.
- alloc_idx0  out  IDX_W  index granted to port 0.
- alloc_idx1  out  IDX_W  index granted to port 1.
- free_en  in  2  per-port release strobe.
- free_idx0  in  IDX_W  index released on port 0.
- free_idx1  in  IDX_W  index released on port 1.
- free_count  out  IDX_W+1  registered number of free entries.
- busy_vec  out  N_ENTRIES  registered; bit i is 1 when entry i is allocated.
- err_double_free  out  1  registered one-cycle pulse on an illegal release.

## Operation
- State:
  - free_map[N_ENTRIES-1:0], with 1 meaning free.
  - free_count.
  - err_double_free.
- Reset values (asynchronous):
  - free_map = all ones, with bit 0 cleared if RESERVE_ZERO. Default value is 32'hFFFF_FFFE.
  - free_count = 31 when RESERVE_ZERO, otherwise 32.
  - busy_vec = ~free_map.
  - err_double_free = 0.
- Encoding:
  - first = lowest set bit of free_map.
  - second = next-lowest set bit of free_map.
- Grant rules, with port 0 having priority:
  - alloc_valid[0] = alloc_req[0] and free_count ≥ 1.
  - alloc_idx0 = first.
  - If alloc_req[0] is asserted: alloc_valid[1] = alloc_req[1] and free_count ≥ 2, and alloc_idx1 = second.
  - If alloc_req[0] is not asserted: alloc_valid[1] = alloc_req[1] and free_count ≥ 1, and alloc_idx1 = first.
  - Indices on a port whose alloc_valid is 0 are don't-care. Drive them as 0.
- A request without a grant is dropped, not queued. The requester retries on a later cycle.
- Release:
  - When free_en[k] is set, free_idx_k sets its free_map bit on the next edge.
  - A release is illegal if the bit is already free. An illegal release is ignored and err_double_free pulses on the next cycle.
  - If both ports release the same index in one cycle, the entry is freed once and err_double_free pulses.
  - A release of entry 0 while RESERVE_ZERO is set is ignored with no error.
- Next state:
  - free_map_next = (free_map & ~granted_onehots) | legal_release_onehots.
  - free_count_next = free_count − number of grants + number of legal distinct releases.
  - free_count never wraps.
- Simultaneous alloc and release: releases do not bypass into the same cycle's grants. An entry released in cycle t can be granted at the earliest in cycle t+1.

## Timing
- Grant latency is 0 cycles: alloc_valid and alloc_idx are combinational in the cycle alloc_req is presented.
- The bitmap update is visible one cycle later, in busy_vec and free_count.
- Release latency is 1 cycle.
- Reset mid-operation clears all allocations immediately, asynchronously. Outputs return to their reset values while rst_n is low. Grants are computed from the reset bitmap.
- Empty pool (free_count = 0): both alloc_valid bits are 0.
- One entry free with both ports requesting: only port 0 is granted.
- Full pool: no special case; releases of free entries are errors.

## Structure
- Shared package proc_alloc_pkg holds:
  - N_ENTRIES and IDX_W constants.
  - typedef idx_t, logic [IDX_W-1:0].
  - typedef map_t, logic [N_ENTRIES-1:0].
- Sub-module prio_enc2: a combinational first/second lowest-set-bit encoder.
  - Input: map_t.
  - Outputs: first, first_vld, second, second_vld.
  - It is instantiated once, on free_map.

## Test plan
- Reset, no requests → free_count = 31, busy_vec = 32'h0000_0001, alloc_valid = 2'b00, err_double_free = 0.
- alloc_req = 2'b11 for one cycle after reset → alloc_idx0 = 1, alloc_idx1 = 2, alloc_valid = 2'b11. Next cycle: free_count = 29, busy_vec = 32'h0000_0007.
- alloc_req = 2'b10 alone after reset → alloc_valid = 2'b10, alloc_idx1 = 1. Then allocate until free_count = 1 and request 2'b11 → only port 0 is granted, with index 31.
- With pool empty:
  - Release 7 on port 0 while requesting 2'b01 in the same cycle → no grant that cycle.
  - Next cycle: grant index 7, free_count = 1 → 0 after the edge.
- Release index 9 while it is free, and separately release 12 on both ports in one cycle after allocating it → err_double_free pulses for exactly one cycle each time; entry 12 is freed once; free_count rises by 1.
- Assert rst_n low asynchronously mid-cycle after 20 allocations → busy_vec = 32'h0000_0001 and free_count = 31 immediately, without waiting for a clock edge.
